fc_executor: RTL

Fast-command executor that consumes the one-hot decoded command word from the fast-command decoder and turns it into the timed chip-level actions. It maintains the bunch-crossing ID counter, the L1A pulse and counter, a delayed charge-injection strobe, and the waveform-sampler run/stop state. It sits directly downstream of the decoder in the 40 MHz aligned clock domain and drives the pixel matrix and readout control.

---
 rtl/fc_executor.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/fc_executor.sv
// Fast-command executor: turns one-hot decoded fast commands into BCID/L1A
// bookkeeping, delayed charge-injection strobes and waveform-sampler control.
module fc_executor #(
  parameter int BCID_MAX   = 3563,
  parameter int QINJ_DLY_W = 5
) (
  input  logic                  clk40_aligned,
  input  logic                  rst,
  input  logic [9:0]            fcd,
  input  logic [11:0]           bcidOffset,
  input  logic [QINJ_DLY_W-1:0] qinjDelay,
  output logic [11:0]           bcid,
  output logic                  bcrPulse,
  output logic                  l1aPulse,
  output logic [7:0]            l1aCnt,
  output logic                  syncPulse,
  output logic                  linkResetPulse,
  output logic                  qinjPulse,
  output logic                  qinjBusy,
  output logic                  wsActive,
  output logic                  wsStartPulse,
  output logic                  wsStopPulse,
  output logic [7:0]            invalidCnt
);

  localparam logic [11:0] L_BCID_MAX = 12'(BCID_MAX);

  typedef enum logic { QIDLE = 1'b0, QWAIT = 1'b1 } qinj_state_t;
  typedef enum logic { WIDLE = 1'b0, WRUN  = 1'b1 } ws_state_t;

  // Command word and its operands are captured together, so a command always
  // executes with the offset/delay that accompanied it.
  logic [9:0]            r_fcd;
  logic [11:0]           r_bcid_offset;
  logic [QINJ_DLY_W-1:0] r_qinj_delay;

  logic [11:0]           r_bcid;
  logic                  r_bcr_pulse;
  logic                  r_l1a_pulse;
  logic [7:0]            r_l1a_cnt;
  logic                  r_sync_pulse;
  logic                  r_link_reset_pulse;
  logic                  r_qinj_pulse;
  logic                  r_qinj_busy;
  logic [QINJ_DLY_W-1:0] r_qinj_cnt;
  qinj_state_t           r_qinj_state;
  ws_state_t             r_ws_state;
  logic                  r_ws_start_pulse;
  logic                  r_ws_stop_pulse;
  logic [7:0]            r_invalid_cnt;

  logic w_multi;
  logic w_valid;
  logic w_link_rst;
  logic w_bcr;
  logic w_sync;
  logic w_l1a_cr;
  logic w_qinj;
  logic w_l1a;
  logic w_l1a_bcr;
  logic w_ws_start;
  logic w_ws_stop;
  logic [11:0] w_bcid_load;

  // A word with two or more bits set has a non-zero value after clearing its lowest set bit.
  assign w_multi    = |(r_fcd & (r_fcd - 10'd1));
  assign w_valid    = ~w_multi;
  assign w_link_rst = w_valid & r_fcd[1];
  assign w_bcr      = w_valid & r_fcd[2];
  assign w_sync     = w_valid & r_fcd[3];
  assign w_l1a_cr   = w_valid & r_fcd[4];
  assign w_qinj     = w_valid & r_fcd[5];
  assign w_l1a      = w_valid & r_fcd[6];
  assign w_l1a_bcr  = w_valid & r_fcd[7];
  assign w_ws_start = w_valid & r_fcd[8];
  assign w_ws_stop  = w_valid & r_fcd[9];

  assign w_bcid_load = (r_bcid_offset > L_BCID_MAX) ? 12'd0 : r_bcid_offset;

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from pre-edge values, independent of block ordering.
  always_ff @(posedge clk40_aligned or posedge rst) begin
    if (rst) begin
      r_fcd         <= '0;
      r_bcid_offset <= '0;
      r_qinj_delay  <= '0;
    end else begin
      r_fcd         <= fcd;
      r_bcid_offset <= bcidOffset;
      r_qinj_delay  <= qinjDelay;
    end
  end

  always_ff @(posedge clk40_aligned or posedge rst) begin
    if (rst) begin
      r_bcid             <= '0;
      r_bcr_pulse        <= 1'b0;
      r_l1a_pulse        <= 1'b0;
      r_l1a_cnt          <= '0;
      r_sync_pulse       <= 1'b0;
      r_link_reset_pulse <= 1'b0;
      r_invalid_cnt      <= '0;
    end else begin
      if (w_bcr || w_l1a_bcr)
        r_bcid <= w_bcid_load;
      else if (r_bcid >= L_BCID_MAX)
        r_bcid <= 12'd0;
      else
        r_bcid <= r_bcid + 12'd1;

      r_bcr_pulse        <= w_bcr | w_l1a_bcr;
      r_l1a_pulse        <= w_l1a | w_l1a_bcr;
      r_sync_pulse       <= w_sync;
      r_link_reset_pulse <= w_link_rst;

      if (w_l1a_cr)
        r_l1a_cnt <= 8'd0;
      else if (w_l1a || w_l1a_bcr)
        r_l1a_cnt <= r_l1a_cnt + 8'd1;

      if (w_multi && (r_invalid_cnt != 8'hFF))
        r_invalid_cnt <= r_invalid_cnt + 8'd1;
    end
  end

  // Charge injection: the pulse register doubles as the "last waiting cycle"
  // marker, so QWAIT is left on the edge after the pulse has been shown.
  always_ff @(posedge clk40_aligned or posedge rst) begin
    if (rst) begin
      r_qinj_state <= QIDLE;
      r_qinj_cnt   <= '0;
      r_qinj_busy  <= 1'b0;
      r_qinj_pulse <= 1'b0;
    end else if (w_link_rst) begin
      r_qinj_state <= QIDLE;
      r_qinj_cnt   <= '0;
      r_qinj_busy  <= 1'b0;
      r_qinj_pulse <= 1'b0;
    end else begin
      case (r_qinj_state)
        QIDLE: begin
          r_qinj_pulse <= 1'b0;
          if (w_qinj) begin
            r_qinj_cnt   <= r_qinj_delay;
            r_qinj_busy  <= 1'b1;
            r_qinj_pulse <= (r_qinj_delay == '0);
            r_qinj_state <= QWAIT;
          end
        end
        QWAIT: begin
          if (r_qinj_pulse) begin
            r_qinj_pulse <= 1'b0;
            r_qinj_busy  <= 1'b0;
            r_qinj_state <= QIDLE;
          end else begin
            r_qinj_cnt   <= r_qinj_cnt - QINJ_DLY_W'(1);
            r_qinj_pulse <= (r_qinj_cnt == QINJ_DLY_W'(1));
          end
        end
        default: begin
          r_qinj_state <= QIDLE;
          r_qinj_busy  <= 1'b0;
          r_qinj_pulse <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk40_aligned or posedge rst) begin
    if (rst) begin
      r_ws_state       <= WIDLE;
      r_ws_start_pulse <= 1'b0;
      r_ws_stop_pulse  <= 1'b0;
    end else begin
      r_ws_start_pulse <= 1'b0;
      r_ws_stop_pulse  <= 1'b0;
      if (w_link_rst) begin
        r_ws_state <= WIDLE;
      end else begin
        case (r_ws_state)
          WIDLE: if (w_ws_start) begin
            r_ws_state       <= WRUN;
            r_ws_start_pulse <= 1'b1;
          end
          WRUN: if (w_ws_stop) begin
            r_ws_state      <= WIDLE;
            r_ws_stop_pulse <= 1'b1;
          end
          default: r_ws_state <= WIDLE;
        endcase
      end
    end
  end

  assign bcid           = r_bcid;
  assign bcrPulse       = r_bcr_pulse;
  assign l1aPulse       = r_l1a_pulse;
  assign l1aCnt         = r_l1a_cnt;
  assign syncPulse      = r_sync_pulse;
  assign linkResetPulse = r_link_reset_pulse;
  assign qinjPulse      = r_qinj_pulse;
  assign qinjBusy       = r_qinj_busy;
  assign wsActive       = (r_ws_state == WRUN);
  assign wsStartPulse   = r_ws_start_pulse;
  assign wsStopPulse    = r_ws_stop_pulse;
  assign invalidCnt     = r_invalid_cnt;

endmodule
